// File: rtl/vertex_fetch_ctrl.sv
// Walks the primitive ROM, gathering WORDS_PER_PRIM words per primitive into a valid/ready bundle.
// Latency: 4 fetch cycles + 1 present cycle per primitive; bundle held stable while not ready.
module vertex_fetch_ctrl #(
    parameter int ADDR_W         = 4,
    parameter int DATA_W         = 24,
    parameter int WORDS_PER_PRIM = 4,
    parameter int NUM_PRIM       = 4,
    localparam int IDX_W  = (NUM_PRIM > 1) ? $clog2(NUM_PRIM) : 1,
    localparam int WORD_W = (WORDS_PER_PRIM > 1) ? $clog2(WORDS_PER_PRIM) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic              prim_valid_o,
    input  logic              prim_ready_i,
    output logic [DATA_W-1:0] prim_v0_o,
    output logic [DATA_W-1:0] prim_v1_o,
    output logic [DATA_W-1:0] prim_v2_o,
    output logic [DATA_W-1:0] prim_attr_o,
    output logic [IDX_W-1:0]  prim_idx_o,
    output logic              prim_degen_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    prim_q, prim_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [DATA_W-1:0]   slot_q [WORDS_PER_PRIM];
    logic [DATA_W-1:0]   slot_d [WORDS_PER_PRIM];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            prim_q  <= '0;
            word_q  <= '0;
            for (int i = 0; i < WORDS_PER_PRIM; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            prim_q  <= prim_d;
            word_q  <= word_d;
            for (int i = 0; i < WORDS_PER_PRIM; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        prim_d  = prim_q;
        word_d  = word_q;
        for (int i = 0; i < WORDS_PER_PRIM; i++) begin
            slot_d[i] = slot_q[i];
        end
        rom_addr_o   = '0;
        prim_valid_o = 1'b0;
        done_o       = 1'b0;
        busy_o       = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_FETCH;
                    prim_d  = '0;
                    word_d  = '0;
                end
            end
            S_FETCH: begin
                // Address depends only on registered counters, never on prim_ready_i.
                rom_addr_o = ADDR_W'(prim_q) * ADDR_W'(WORDS_PER_PRIM) + ADDR_W'(word_q);
                slot_d[word_q] = rom_data_i;
                if (word_q == WORD_W'(WORDS_PER_PRIM - 1)) begin
                    state_d = S_PRESENT;
                end else begin
                    word_d = word_q + WORD_W'(1);
                end
            end
            S_PRESENT: begin
                prim_valid_o = 1'b1;
                if (prim_ready_i) begin
                    if (prim_q == IDX_W'(NUM_PRIM - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        prim_d  = prim_q + IDX_W'(1);
                        word_d  = '0;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign prim_v0_o   = slot_q[0];
    assign prim_v1_o   = slot_q[1];
    assign prim_v2_o   = slot_q[2];
    assign prim_attr_o = slot_q[3];
    assign prim_idx_o  = prim_q;

    // Gated by valid so the flag never reflects a half-refilled bundle during FETCH.
    assign prim_degen_o = prim_valid_o &&
                          ((slot_q[0] == slot_q[1]) ||
                           (slot_q[0] == slot_q[2]) ||
                           (slot_q[1] == slot_q[2]));

endmodule

// File: tb/tb_vertex_fetch_ctrl.sv
// Directed bench for vertex_fetch_ctrl with a behavioural ROM and assertion-based checks.
module tb_vertex_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        prim_ready;
    logic [3:0]  rom_addr;
    logic [23:0] rom_data;
    logic        prim_valid;
    logic [23:0] v0, v1, v2, attr;
    logic [1:0]  prim_idx;
    logic        degen;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;
    bit extra_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vertex_fetch_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .rom_addr_o   (rom_addr),
        .rom_data_i   (rom_data),
        .prim_valid_o (prim_valid),
        .prim_ready_i (prim_ready),
        .prim_v0_o    (v0),
        .prim_v1_o    (v1),
        .prim_v2_o    (v2),
        .prim_attr_o  (attr),
        .prim_idx_o   (prim_idx),
        .prim_degen_o (degen),
        .busy_o       (busy),
        .done_o       (done)
    );

    function automatic logic [23:0] rom_f(input logic [3:0] a);
        case (a)
            4'd0:    return 24'h863045;
            4'd1:    return 24'h702010;
            4'd2:    return 24'h292910;
            4'd3:    return 24'h157210;
            4'd4:    return 24'h0A0B0C;
            4'd5:    return 24'h1A1B1C;
            4'd6:    return 24'h2A2B2C;
            4'd7:    return 24'hC0FFEE;
            4'd8:    return 24'h123456;
            4'd9:    return 24'h654321;
            4'd10:   return 24'h0F0F0F;
            4'd11:   return 24'hABCDEF;
            4'd12:   return 24'h101010;
            4'd13:   return 24'h101010;
            4'd14:   return 24'h801010;
            4'd15:   return 24'h108010;
            default: return 24'h000000;
        endcase
    endfunction

    assign rom_data = rom_f(rom_addr);

    function automatic logic [95:0] exp_bundle(input int p);
        return {rom_f(4'(4 * p)), rom_f(4'(4 * p + 1)), rom_f(4'(4 * p + 2)), rom_f(4'(4 * p + 3))};
    endfunction

    function automatic int rel();
        return cyc - t0 + 1;
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (extra_en) start = (rel() == 3 || rel() == 12);
    endtask

    task automatic frame(input int stall);
        int n;
        start = 1'b1;
        @(negedge clk);
        t0 = cyc;
        start = 1'b0;
        prim_ready = 1'b1;
        for (int w = 0; w < 4; w++) begin
            chk("fetch_addr", 96'(rom_addr), 96'(w));
            chk("fetch_busy", 96'(busy), 96'(1));
            tick();
        end
        for (int p = 0; p < 4; p++) begin
            n = 0;
            while (!prim_valid && n < 40) begin
                tick();
                n++;
            end
            chk("valid_seen", 96'(prim_valid), 96'(1));
            chk("bundle_time", 96'(rel()), 96'(5 + 5 * p + ((p >= 2) ? stall : 0)));
            chk("bundle_idx", 96'(prim_idx), 96'(p));
            chk("bundle_dat", {v0, v1, v2, attr}, exp_bundle(p));
            chk("bundle_degen", 96'(degen), 96'((p == 3) ? 1 : 0));
            if (p == 1 && stall > 0) begin
                prim_ready = 1'b0;
                for (int i = 0; i < stall; i++) begin
                    tick();
                    chk("stall_valid", 96'(prim_valid), 96'(1));
                    chk("stall_dat", {v0, v1, v2, attr}, exp_bundle(1));
                    chk("stall_idx", 96'(prim_idx), 96'(1));
                    chk("stall_addr", 96'(rom_addr), 96'(0));
                end
                prim_ready = 1'b1;
            end
            tick();
            chk("valid_drop", 96'(prim_valid), 96'(0));
            if (p < 3) chk("next_addr", 96'(rom_addr), 96'(4 * (p + 1)));
        end
        chk("done_pulse", 96'(done), 96'(1));
        chk("done_time", 96'(rel()), 96'(21 + stall));
        chk("done_busy", 96'(busy), 96'(1));
        tick();
        chk("after_done", 96'(done), 96'(0));
        chk("after_busy", 96'(busy), 96'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog bench did not finish observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;
        rst = 1'b1;
        start = 1'b0;
        prim_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 96'(prim_valid), 96'(0));
        chk("rst_busy", 96'(busy), 96'(0));
        chk("rst_done", 96'(done), 96'(0));
        chk("rst_addr", 96'(rom_addr), 96'(0));
        chk("rst_idx", 96'(prim_idx), 96'(0));
        chk("rst_degen", 96'(degen), 96'(0));
        chk("rst_dat", {v0, v1, v2, attr}, 96'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 96'(busy), 96'(0));

        // T1 + T3: plain frame with degenerate last primitive
        frame(0);
        // T2: bundle 1 stalled for 7 cycles
        frame(7);
        // T4: start pulses while busy are ignored
        extra_en = 1'b1;
        frame(0);
        extra_en = 1'b0;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (prim_valid || busy || done) seen = 1'b1;
        end
        chk("t4_no_second_frame", 96'(seen), 96'(0));

        // T5: reset while bundle 2 is stalled
        start = 1'b1;
        @(negedge clk);
        t0 = cyc;
        start = 1'b0;
        prim_ready = 1'b1;
        n = 0;
        while (!(prim_valid && prim_idx == 2'd2) && n < 40) begin
            tick();
            n++;
        end
        prim_ready = 1'b0;
        chk("t5_reach_idx", 96'(prim_idx), 96'(2));
        tick();
        tick();
        chk("t5_held_valid", 96'(prim_valid), 96'(1));
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_valid", 96'(prim_valid), 96'(0));
        chk("t5_rst_busy", 96'(busy), 96'(0));
        chk("t5_rst_addr", 96'(rom_addr), 96'(0));
        chk("t5_rst_idx", 96'(prim_idx), 96'(0));
        chk("t5_rst_done", 96'(done), 96'(0));
        @(negedge clk);
        rst = 1'b0;
        prim_ready = 1'b1;
        @(negedge clk);
        chk("t5_idle_busy", 96'(busy), 96'(0));
        frame(0);
        // T6: next frame started in the cycle right after done
        frame(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
